// File: rtl/dcache_wb_ctrl.sv
// dcache_wb_ctrl: direct-mapped write-back write-allocate L1 data cache controller.
// Ports: clk_i/rst_i (async active-low) clock and reset; address_i, write_data_i,
// MemRead_i, MemWrite_i CPU request; read_data_o, stall_o CPU response;
// mem_data_i, mem_ack_i refill data and completion pulse from memory;
// mem_data_o, mem_addr_o, mem_enable_o, mem_write_o line request to memory.
module dcache_wb_ctrl #(
    parameter int NUM_LINES = 32,
    parameter int LINE_BITS = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          address_i,
    input  logic [31:0]          write_data_i,
    input  logic                 MemRead_i,
    input  logic                 MemWrite_i,
    output logic [31:0]          read_data_o,
    output logic                 stall_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic [31:0]          mem_addr_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o
);
    typedef enum logic [2:0] {
        IDLE                 = 3'd0,
        READ_WAIT_ACK_WRITE  = 3'd1,
        READ_WAIT_ACK_READ   = 3'd2,
        WRITE_WAIT_ACK_WRITE = 3'd3,
        WRITE_WAIT_ACK_READ  = 3'd4
    } state_t;

    // tag entry: [23] valid, [22] dirty, [21:0] tag
    logic [23:0]          tag_mem  [NUM_LINES];
    logic [LINE_BITS-1:0] data_mem [NUM_LINES];
    state_t               state;
    logic [4:0]           idx;
    logic [21:0]          tag;
    logic [7:0]           bit_sel;
    logic [23:0]          entry;
    logic [LINE_BITS-1:0] line;
    logic                 req, hit, in_wb, in_fill, store_hit;
    logic                 unused;

    assign idx       = address_i[9:5];
    assign tag       = address_i[31:10];
    assign bit_sel   = {address_i[4:2], 5'b0};
    assign unused    = ^address_i[1:0];
    assign entry     = tag_mem[idx];
    assign line      = data_mem[idx];
    assign req       = MemRead_i | MemWrite_i;
    assign hit       = entry[23] && entry[21:0] == tag;
    assign in_wb     = state == READ_WAIT_ACK_WRITE || state == WRITE_WAIT_ACK_WRITE;
    assign in_fill   = state == READ_WAIT_ACK_READ || state == WRITE_WAIT_ACK_READ;
    assign store_hit = state == IDLE && MemWrite_i && hit;

    // gating with rst_i keeps stall low while reset is held with a request pending
    assign stall_o      = rst_i && req && (state != IDLE || !hit);
    assign read_data_o  = (MemRead_i && hit) ? line[bit_sel +: 32] : '0;
    assign mem_enable_o = in_wb || in_fill;
    assign mem_write_o  = in_wb;
    assign mem_addr_o   = in_wb ? {entry[21:0], idx, 5'b0} : in_fill ? {address_i[31:5], 5'b0} : '0;
    assign mem_data_o   = in_wb ? line : '0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            for (int i = 0; i < NUM_LINES; i++) tag_mem[i] <= '0;
        end else begin
            case (state)
                IDLE:
                    if (req && !hit)
                        state <= (entry[23] && entry[22]) ?
                                 (MemWrite_i ? WRITE_WAIT_ACK_WRITE : READ_WAIT_ACK_WRITE) :
                                 (MemWrite_i ? WRITE_WAIT_ACK_READ : READ_WAIT_ACK_READ);
                    else if (store_hit)
                        tag_mem[idx][22] <= 1'b1;
                READ_WAIT_ACK_WRITE:  if (mem_ack_i) state <= READ_WAIT_ACK_READ;
                WRITE_WAIT_ACK_WRITE: if (mem_ack_i) state <= WRITE_WAIT_ACK_READ;
                READ_WAIT_ACK_READ, WRITE_WAIT_ACK_READ:
                    if (mem_ack_i) begin
                        tag_mem[idx] <= {2'b10, tag};
                        state        <= IDLE;
                    end
                default: state <= IDLE;
            endcase
        end
    end

    // line storage survives reset; only the tags are invalidated
    always_ff @(posedge clk_i) begin
        if (in_fill && mem_ack_i)
            data_mem[idx] <= mem_data_i;
        else if (store_hit)
            data_mem[idx][bit_sel +: 32] <= write_data_i;
    end
endmodule

// File: tb/tb_dcache_wb_ctrl.sv
// tb_dcache_wb_ctrl: directed, model-checked bench for dcache_wb_ctrl.
module tb_dcache_wb_ctrl;
    localparam int LAT = 1;

    logic         clk_i = 0;
    logic         rst_i;
    logic [31:0]  address_i, write_data_i, read_data_o, mem_addr_o;
    logic         MemRead_i, MemWrite_i, stall_o, mem_ack_i, mem_enable_o, mem_write_o;
    logic [255:0] mem_data_i, mem_data_o;

    dcache_wb_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .address_i(address_i), .write_data_i(write_data_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .read_data_o(read_data_o),
        .stall_o(stall_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o), .mem_enable_o(mem_enable_o),
        .mem_write_o(mem_write_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // backing memory: unwritten lines hold word w = line_address + w
    logic [255:0] mem [int unsigned];
    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        if (mem.exists(a)) return mem[a];
        for (int w = 0; w < 8; w++) l[32*w +: 32] = a + w;
        return l;
    endfunction

    // transaction-level cache model
    typedef struct { logic we; logic [31:0] addr; logic [255:0] data; } txn_t;
    txn_t         q[$];
    logic         mv [32];
    logic         md [32];
    logic [21:0]  mt [32];
    logic [255:0] mdata [32];

    function automatic logic mhit(input logic [31:0] a);
        return mv[a[9:5]] && mt[a[9:5]] == a[31:10];
    endfunction

    // compare at negedge+2 against the model, then advance the model across the coming posedge
    always begin : cmp
        logic h, r, busy;
        int   i;
        @(negedge clk_i);
        #2;
        if (!rst_i) begin
            for (int k = 0; k < 32; k++) begin mv[k] = 0; md[k] = 0; end
            q.delete();
        end
        h    = mhit(address_i);
        r    = MemRead_i | MemWrite_i;
        busy = rst_i && q.size() != 0;
        i    = int'(address_i[9:5]);
        chk("stall", stall_o, rst_i && r && (busy || !h));
        chk("mem_enable", mem_enable_o, busy);
        chk("mem_write", mem_write_o, busy && q[0].we);
        chk("mem_addr", mem_addr_o, busy ? q[0].addr : 32'h0);
        chk("mem_data", mem_data_o, (busy && q[0].we) ? q[0].data : 256'h0);
        if (!MemWrite_i)
            chk("read_data", read_data_o, (MemRead_i && h) ? mdata[i][32*int'(address_i[4:2]) +: 32] : 32'h0);
        if (rst_i) begin
            if (q.size() != 0) begin
                if (mem_ack_i) begin
                    if (!q[0].we) begin
                        i        = int'(q[0].addr[9:5]);
                        mv[i]    = 1;
                        md[i]    = 0;
                        mt[i]    = q[0].addr[31:10];
                        mdata[i] = mem_data_i;
                    end
                    void'(q.pop_front());
                end
            end else if (r) begin
                if (!h) begin
                    if (mv[i] && md[i]) q.push_back('{1'b1, {mt[i], address_i[9:5], 5'b0}, mdata[i]});
                    q.push_back('{1'b0, {address_i[31:5], 5'b0}, 256'h0});
                end else if (MemWrite_i) begin
                    mdata[i][32*int'(address_i[4:2]) +: 32] = write_data_i;
                    md[i] = 1;
                end
            end
        end
    end

    // memory responder, run once per negedge from the stimulus process
    int   cnt = 0;
    logic force_ack = 0;
    task automatic step();
        @(negedge clk_i);
        if (!rst_i) begin
            mem_ack_i = 0;
            cnt = 0;
        end else if (mem_ack_i) mem_ack_i = 0;
        else if (force_ack) mem_ack_i = 1;
        else if (mem_enable_o) begin
            if (cnt == LAT) begin
                mem_ack_i = 1;
                cnt = 0;
                if (mem_write_o) mem[mem_addr_o] = mem_data_o;
                else mem_data_i = line_of(mem_addr_o);
            end else cnt++;
        end
    endtask

    int           first_state;
    logic [31:0]  wb_addr, fill_addr;
    logic [255:0] wb_data;
    task automatic watch();
        if (first_state == 0 && int'(dut.state) != 0) first_state = int'(dut.state);
        if (mem_enable_o && mem_write_o && wb_addr === 32'hFFFF_FFFF) begin
            wb_addr = mem_addr_o;
            wb_data = mem_data_o;
        end
        if (mem_enable_o && !mem_write_o && fill_addr === 32'hFFFF_FFFF) fill_addr = mem_addr_o;
    endtask

    task automatic settle(output int stalls);
        stalls = 0;
        first_state = 0;
        wb_addr = '1;
        fill_addr = '1;
        wb_data = '0;
        #3;
        watch();
        while (stall_o && stalls < 50) begin
            step();
            stalls++;
            #3;
            watch();
        end
        if (stall_o) chk("stall_timeout", 1'b1, 1'b0);
    endtask

    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, output int stalls);
        step();
        MemRead_i = rd;
        MemWrite_i = wr;
        address_i = a;
        write_data_i = wd;
        settle(stalls);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        rst_i = 0;
        MemRead_i = 0;
        MemWrite_i = 0;
        address_i = 0;
        write_data_i = 0;
        mem_ack_i = 0;
        mem_data_i = 0;
        mem[32'h0] = {192'h0, 32'h7, 32'h5};
        repeat (3) step();
        rst_i = 1;
        #3;
        chk("reset_stall", stall_o, 1'b0);
        chk("reset_enable", mem_enable_o, 1'b0);
        chk("reset_rdata", read_data_o, 32'h0);

        access(1, 0, 32'h4, 0, st);
        chk("t1_state", first_state, 2);
        chk("t1_fill_addr", fill_addr, 32'h0);
        chk("t1_rdata", read_data_o, 32'h7);
        chk("t1_stalls", st, 3);

        access(0, 1, 32'h8, 32'hDEADBEEF, st);
        chk("t2_stalls", st, 0);

        access(1, 0, 32'h400, 0, st);
        chk("t3_state", first_state, 1);
        chk("t3_wb_addr", wb_addr, 32'h0);
        chk("t3_wb_word2", wb_data[95:64], 32'hDEADBEEF);
        chk("t3_fill_addr", fill_addr, 32'h400);
        chk("t3_rdata", read_data_o, 32'h400);
        chk("t3_stalls", st, 6);

        access(1, 1, 32'h404, 32'h12345678, st);
        chk("t6_stalls", st, 0);
        chk("t6_enable", mem_enable_o, 1'b0);
        access(1, 0, 32'h404, 0, st);
        chk("t6_rdata", read_data_o, 32'h12345678);

        step();
        MemRead_i = 0;
        MemWrite_i = 0;
        force_ack = 1;
        step();
        force_ack = 0;
        access(1, 0, 32'h404, 0, st);
        chk("idle_ack_stalls", st, 0);
        chk("idle_ack_rdata", read_data_o, 32'h12345678);

        access(1, 0, 32'h8, 0, st);
        chk("evict_state", first_state, 1);
        chk("evict_wb_addr", wb_addr, 32'h400);
        chk("evict_wb_word1", wb_data[63:32], 32'h12345678);
        chk("evict_rdata", read_data_o, 32'hDEADBEEF);

        access(0, 1, 32'h20, 32'hCAFEF00D, st);
        chk("t4_state", first_state, 4);
        chk("t4_fill_addr", fill_addr, 32'h20);
        chk("t4_stalls", st, 3);
        access(1, 0, 32'h20, 0, st);
        chk("t4_rdata", read_data_o, 32'hCAFEF00D);

        step();
        MemRead_i = 1;
        MemWrite_i = 0;
        address_i = 32'h40;
        step();
        #1;
        rst_i = 0;
        #2;
        chk("t5_state", int'(dut.state), 0);
        chk("t5_enable", mem_enable_o, 1'b0);
        chk("t5_stall", stall_o, 1'b0);
        step();
        rst_i = 1;
        #1;
        chk("t5_remiss", stall_o, 1'b1);
        #0;
        begin
            step();
            settle(st);
        end
        chk("t5_rdata", read_data_o, 32'h40);

        access(1, 0, 32'h24, 0, st);
        chk("t5_clean_state", first_state, 2);
        chk("t5_clean_stalls", st, 3);
        chk("t5_rdata2", read_data_o, 32'h21);

        step();
        MemRead_i = 0;
        MemWrite_i = 0;
        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dcache_wb_ctrl.md
# dcache_wb_ctrl

Direct-mapped, write-back, write-allocate L1 data cache controller between the CPU MEM stage and the 256-bit line-oriented data memory. It holds 32 lines of 32 bytes (1 KB) and serves 32-bit loads and stores. It raises a stall toward the pipeline on a miss, writes back a dirty victim line, refills from memory, then completes the access as a hit.

## Interface
- NUM_LINES, 32, line count; index width is log2(NUM_LINES) = 5.
- LINE_BITS, 256, line width in bits; offset is 5 bits, word select is address[4:2].
- clk_i  in  1  clock; one clock domain, all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous and active-low.
- address_i  in  32  CPU byte address: tag [31:10], index [9:5], offset [4:0].
- write_data_i  in  32  store data.
- MemRead_i  in  1  load request, held by the CPU while stall_o is high.
- MemWrite_i  in  1  store request, held by the CPU while stall_o is high; wins over MemRead_i.
- read_data_o  out  32  load data, valid when stall_o is low.
- stall_o  out  1  pipeline stall.
- mem_data_i  in  256  refill line, valid while mem_ack_i is high.
- mem_ack_i  in  1  one-cycle transaction-complete pulse.
- mem_data_o  out  256  write-back line.
- mem_addr_o  out  32  line address, with [4:0] = 0.
- mem_enable_o  out  1  memory request.
- mem_write_o  out  1  high for write-back, low for refill.

## Operation
- Storage: the tag array is 32×24 bits: bit 23 valid, bit 22 dirty, bits [21:0] tag. The data array is 32×256 bits.
- Word w of a line occupies bits [32w+31:32w].
- Request: req = MemRead_i | MemWrite_i.
- Hit: valid and the stored tag equals address_i[31:10].
- State encoding (3 bits, fixed):
  - IDLE = 0
  - READ_WAIT_ACK_WRITE = 1
  - READ_WAIT_ACK_READ = 2
  - WRITE_WAIT_ACK_WRITE = 3
  - WRITE_WAIT_ACK_READ = 4
- IDLE, request hits:
  - Load: read_data_o is the selected word, combinationally.
  - Store: on the clock edge, the word is written and dirty is set.
- IDLE, request misses:
  - Victim dirty → go to *_WAIT_ACK_WRITE (READ_ or WRITE_ per the request type).
  - Otherwise → go to *_WAIT_ACK_READ.
- *_WAIT_ACK_WRITE:
  - mem_enable_o = 1, mem_write_o = 1.
  - mem_addr_o = {stored tag, index, 5'b0}; mem_data_o = victim line.
  - On mem_ack_i → the matching *_WAIT_ACK_READ.
- *_WAIT_ACK_READ:
  - mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {address_i[31:5], 5'b0}.
  - On mem_ack_i: the line is written from mem_data_i, tag set, valid = 1, dirty = 0, state → IDLE.
- After a refill the held request hits in IDLE. A store then merges its word and sets dirty.
- stall_o = req & (state != IDLE | !hit), combinational.
- Outputs outside wait states: mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0.
- read_data_o = 0 when MemRead_i is low or on a miss.

## Timing
- Reset, asserted at any time including mid-miss:
  - state = IDLE; all tag entries are cleared (valid = dirty = 0).
  - The data array is not cleared.
  - Outputs: stall_o = 0, mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0, read_data_o = 0.
- Hit latency: 0 cycles. stall_o is never high for a hit in IDLE.
- Clean miss latency: stall_o rises in the same cycle the request appears. The request is issued next cycle. The fill happens on the ack edge, and stall_o falls in the following cycle.
- Dirty miss: write-back transaction first. The refill request is driven in the cycle after the write-back ack.
- Memory handshake:
  - Memory samples the request while mem_enable_o is high.
  - The ack cycle ends the transaction. mem_addr_o, mem_data_o and mem_write_o are stable from request until ack.
- mem_ack_i in IDLE is ignored.
- A request dropped while in a wait state does not abort the transaction; the refill still completes.
- MemRead_i and MemWrite_i both high: treated as a store.

## Test plan
- Reset, then load 0x0000_0004 with memory line 0 = 256'h...0000_0007_0000_0005 → read miss, READ_WAIT_ACK_READ, mem_addr_o = 0x00000000. After ack, read_data_o = 0x00000007 and stall_o falls.
- Store 0xDEADBEEF to 0x0000_0008 after the test-1 fill → write hit, no stall. Line 0 word 2 = DEADBEEF, dirty = 1.
- Load 0x0000_0400 (same index 0, tag 1) after test 2 → state 1. Write-back to mem_addr 0x00000000 carries DEADBEEF at bits [95:64], then refill from 0x00000400.
- Store to a clean-miss address 0x0000_0020 → state 4, refill, then the word merges and dirty = 1. Total stall = fill latency + 1 cycle.
- Assert rst_i low during READ_WAIT_ACK_READ → immediate IDLE, mem_enable_o = 0, all valid bits = 0. A following load of the same address misses again.
- Both MemRead_i and MemWrite_i high on a hit → data written, read_data_o ignored, no memory traffic.
